fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 19 +
 rtl/inst_fifo.sv | 78 +++++++
 rtl/fetch_unit.sv | 129 ++++++++++++
 tb/tb_fetch_unit.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared CPU package: fetch FSM encoding, reset PC default, NOP word
package fetch_unit_pkg;

  // Fetch sequencer states; STALL is the only state with no request on the bus
  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_STALL   = 2'd1,
    S_DISCARD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

  // Instruction addresses are always word aligned; low bits of any source are dropped
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fifo.sv
// rtl/inst_fifo.sv - small instruction buffer with synchronous flush
module inst_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == FULL_CNT);
  assign do_pop    = pop & ~empty;
  // A full buffer can still take a push when the head leaves in the same cycle
  assign do_push   = push & (~full | do_pop);
  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

  // Next pointers, occupancy and storage; flush wins over any push or pop
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Control state is reset; pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible once counted in
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch sequencer feeding decode through a small buffer
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int            CW         = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [31:0]   RESET_PC_A = align_pc(RESET_PC);

  fetch_state_e  state_q, state_d;
  logic          imem_req_q, imem_req_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   target_pc_q, target_pc_d;

  logic          ack_v;
  logic          pop;
  logic          push;
  logic [CW-1:0] count;
  logic [CW-1:0] count_after_pop;
  logic [CW-1:0] count_after_push;
  logic [63:0]   head;
  logic          empty;

  // Acks are only meaningful against a request we are actually driving
  assign ack_v            = imem_ack & imem_req_q;
  assign pop              = inst_valid & inst_ready & ~redirect;
  assign count_after_pop  = count - CW'(pop);
  assign count_after_push = count_after_pop + 1'b1;

  inst_fifo #(
    .WIDTH (64),
    .DEPTH (DEPTH)
  ) u_inst_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect),
    .push      (push),
    .push_data ({fetch_pc_q, imem_rdata}),
    .pop       (pop),
    .head_data (head),
    .count     (count),
    .empty     (empty)
  );

  // Fetch sequencing: redirect first, then response handling and refill of the buffer
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    target_pc_d = target_pc_q;
    push        = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (redirect) begin
          if (imem_req_q && !ack_v) begin
            // Request in flight: its response must be swallowed before refetching
            state_d     = S_DISCARD;
            target_pc_d = align_pc(redirect_pc);
          end else begin
            fetch_pc_d = align_pc(redirect_pc);
          end
        end else if (ack_v) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + 32'd4;
          if (count_after_push == FULL_CNT) begin
            state_d = S_STALL;
          end
        end
      end
      S_STALL: begin
        if (redirect) begin
          state_d    = S_FETCH;
          fetch_pc_d = align_pc(redirect_pc);
        end else if (count_after_pop < FULL_CNT) begin
          state_d = S_FETCH;
        end
      end
      S_DISCARD: begin
        if (ack_v) begin
          state_d    = S_FETCH;
          fetch_pc_d = redirect ? align_pc(redirect_pc) : target_pc_q;
        end else if (redirect) begin
          target_pc_d = align_pc(redirect_pc);
        end
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
    imem_req_d = (state_d != S_STALL);
  end

  // Sequencer state and registered memory-side outputs
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= S_FETCH;
      imem_req_q  <= 1'b0;
      fetch_pc_q  <= RESET_PC_A;
      target_pc_q <= RESET_PC_A;
    end else begin
      state_q     <= state_d;
      imem_req_q  <= imem_req_d;
      fetch_pc_q  <= fetch_pc_d;
      target_pc_q <= target_pc_d;
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = fetch_pc_q;
  assign inst_valid = ~empty;
  assign inst       = inst_valid ? head[31:0]  : NOP_WORD;
  assign inst_pc    = inst_valid ? head[63:32] : 32'h0000_0000;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_inst;
  logic [31:0] w_inst_pc;
  logic        w_valid;

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] sb [$];

  always #5 clock = ~clock;

  fetch_unit dut (
    .clock       (clock),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  fetch_unit #(
    .RESET_PC (32'hFFFF_FFFC),
    .DEPTH    (4)
  ) dut_w (
    .clock       (clock),
    .reset       (reset),
    .imem_req    (w_req),
    .imem_addr   (w_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .inst        (w_inst),
    .inst_pc     (w_inst_pc),
    .inst_valid  (w_valid),
    .inst_ready  (inst_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  // scoreboard consumer: a delivery happens on the coming edge, compare it now
  task automatic tick();
    logic [63:0] e;
    if (reset && inst_valid && inst_ready && !redirect) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL sb_extra got pc=%h inst=%h want no delivery", inst_pc, inst);
      end else begin
        e = sb.pop_front();
        if ({inst_pc, inst} !== e) begin
          n_err++;
          $display("FAIL sb_deliver got pc=%h inst=%h want pc=%h inst=%h", inst_pc, inst, e[63:32], e[31:0]);
        end
      end
    end
    @(posedge clock);
    #1;
  endtask

  // memory answers with the word at the address the DUT asks for
  task automatic mem_ack(input logic [31:0] exp_pc);
    imem_ack   = 1'b1;
    imem_rdata = mem_word(imem_addr);
    sb.push_back({exp_pc, mem_word(exp_pc)});
  endtask

  task automatic apply_reset();
    reset = 1'b0; redirect = 1'b0; imem_ack = 1'b0; inst_ready = 1'b0;
    tick(); tick();
    sb.delete();
    reset = 1'b1;
  endtask

  task automatic check_drained(input string nm);
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain got %0d pending want 0", nm, sb.size());
    end
  endtask

  task automatic test_reset();
    tick(); tick();
    n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req got %b want 0", imem_req); end
    n_vec++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", inst_valid); end
    n_vec++; if (inst !== 32'h0) begin n_err++; $display("FAIL rst_inst got %h want 0", inst); end
    n_vec++; if (inst_pc !== 32'h0) begin n_err++; $display("FAIL rst_pc got %h want 0", inst_pc); end
    n_vec++; if (w_req !== 1'b0) begin n_err++; $display("FAIL rst_wreq got %b want 0", w_req); end
  endtask

  task automatic test_stream();
    apply_reset();
    inst_ready = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) begin
      n_vec++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL str_req k=%0d got %b want 1", k, imem_req); end
      n_vec++; if (imem_addr !== 32'(4 * k)) begin n_err++; $display("FAIL str_addr got %h want %h", imem_addr, 32'(4 * k)); end
      n_vec++; if (inst_valid !== (k >= 1)) begin n_err++; $display("FAIL str_valid k=%0d got %b want %b", k, inst_valid, k >= 1); end
      mem_ack(32'(4 * k));
      tick();
    end
    imem_ack = 1'b0;
    tick(); tick(); tick();
    check_drained("str");
  endtask

  task automatic test_stall();
    apply_reset();
    inst_ready = 1'b0;
    tick();
    for (int k = 0; k < 2; k++) begin
      n_vec++; if (imem_addr !== 32'(4 * k)) begin n_err++; $display("FAIL stl_addr got %h want %h", imem_addr, 32'(4 * k)); end
      mem_ack(32'(4 * k));
      tick();
    end
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    for (int k = 0; k < 3; k++) begin
      n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL stl_req k=%0d got %b want 0", k, imem_req); end
      tick();
    end
    n_vec++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin n_err++; $display("FAIL stl_head got v=%b pc=%h want v=1 pc=0", inst_valid, inst_pc); end
    imem_ack = 1'b0; inst_ready = 1'b1;
    tick();
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin n_err++; $display("FAIL stl_resume got req=%b addr=%h want req=1 addr=8", imem_req, imem_addr); end
    n_vec++; if (inst_pc !== 32'h4) begin n_err++; $display("FAIL stl_head2 got %h want 4", inst_pc); end
    for (int k = 0; k < 3; k++) begin
      n_vec++; if (imem_addr !== 32'(8 + 4 * k)) begin n_err++; $display("FAIL stl_addr2 got %h want %h", imem_addr, 32'(8 + 4 * k)); end
      mem_ack(32'(8 + 4 * k));
      tick();
    end
    imem_ack = 1'b0;
    tick(); tick(); tick();
    check_drained("stl");
  endtask

  task automatic test_discard(input bit retarget);
    logic [31:0] tgt;
    tgt = retarget ? 32'h300 : 32'h200;
    apply_reset();
    inst_ready = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      mem_ack(32'(4 * k));
      tick();
    end
    n_vec++; if (imem_addr !== 32'h10) begin n_err++; $display("FAIL dsc_pre got %h want 10", imem_addr); end
    imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h200;
    sb.delete();
    tick();
    redirect = 1'b0;
    n_vec++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL dsc_flush got %b want 0", inst_valid); end
    for (int c = 0; c < 3; c++) begin
      n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin n_err++; $display("FAIL dsc_hold c=%0d got req=%b addr=%h want req=1 addr=10", c, imem_req, imem_addr); end
      if (c == 2) begin
        imem_ack = 1'b1; imem_rdata = mem_word(imem_addr);
      end else if (retarget && c == 0) begin
        redirect = 1'b1; redirect_pc = 32'h301;
      end
      tick();
      redirect = 1'b0;
    end
    n_vec++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL dsc_drop got %b want 0", inst_valid); end
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== tgt) begin n_err++; $display("FAIL dsc_new got req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, tgt); end
    mem_ack(tgt);
    tick();
    imem_ack = 1'b0;
    n_vec++; if (inst_valid !== 1'b1 || inst_pc !== tgt) begin n_err++; $display("FAIL dsc_first got v=%b pc=%h want v=1 pc=%h", inst_valid, inst_pc, tgt); end
    tick(); tick();
    check_drained("dsc");
  endtask

  task automatic test_redirect_ack();
    apply_reset();
    inst_ready = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      mem_ack(32'(4 * k));
      tick();
    end
    n_vec++; if (inst_valid !== 1'b1 || inst_pc !== 32'h8) begin n_err++; $display("FAIL rda_pre got v=%b pc=%h want v=1 pc=8", inst_valid, inst_pc); end
    imem_ack = 1'b1; imem_rdata = mem_word(imem_addr);
    redirect = 1'b1; redirect_pc = 32'h203;
    sb.delete();
    tick();
    redirect = 1'b0; imem_ack = 1'b0;
    n_vec++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL rda_flush got %b want 0", inst_valid); end
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin n_err++; $display("FAIL rda_addr got req=%b addr=%h want req=1 addr=200", imem_req, imem_addr); end
    mem_ack(32'h200);
    tick();
    imem_ack = 1'b0;
    tick(); tick();
    check_drained("rda");
  endtask

  task automatic test_wrap();
    apply_reset();
    inst_ready = 1'b0;
    tick();
    n_vec++; if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrp_first got req=%b addr=%h want req=1 addr=fffffffc", w_req, w_addr); end
    imem_ack = 1'b1; imem_rdata = 32'h0BAD_F00D;
    tick();
    n_vec++; if (w_addr !== 32'h0) begin n_err++; $display("FAIL wrp_second got %h want 0", w_addr); end
    n_vec++; if (w_valid !== 1'b1 || w_inst_pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrp_head got v=%b pc=%h want v=1 pc=fffffffc", w_valid, w_inst_pc); end
    tick();
    imem_ack = 1'b0;
    n_vec++; if (w_addr !== 32'h4) begin n_err++; $display("FAIL wrp_third got %h want 4", w_addr); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    inst_ready = 1'b0;
    tick();
    imem_ack = 1'b1; imem_rdata = 32'h1111_2222;
    tick(); tick();
    imem_ack = 1'b0;
    n_vec++; if (inst_valid !== 1'b1 || imem_req !== 1'b0) begin n_err++; $display("FAIL rmd_full got v=%b req=%b want v=1 req=0", inst_valid, imem_req); end
    n_vec++; if (w_valid !== 1'b1 || w_req !== 1'b1 || w_addr !== 32'h4) begin n_err++; $display("FAIL rmd_pend got v=%b req=%b addr=%h want v=1 req=1 addr=4", w_valid, w_req, w_addr); end
    reset = 1'b0;
    tick();
    n_vec++; if (inst_valid !== 1'b0 || imem_req !== 1'b0) begin n_err++; $display("FAIL rmd_rst got v=%b req=%b want v=0 req=0", inst_valid, imem_req); end
    n_vec++; if (inst !== 32'h0 || inst_pc !== 32'h0) begin n_err++; $display("FAIL rmd_inst got inst=%h pc=%h want 0 0", inst, inst_pc); end
    n_vec++; if (w_valid !== 1'b0 || w_req !== 1'b0 || w_inst !== 32'h0) begin n_err++; $display("FAIL rmd_wrst got v=%b req=%b inst=%h want 0 0 0", w_valid, w_req, w_inst); end
    reset = 1'b1;
    tick();
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_err++; $display("FAIL rmd_re got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr); end
    n_vec++; if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL rmd_wre got req=%b addr=%h want req=1 addr=fffffffc", w_req, w_addr); end
    inst_ready = 1'b1;
    mem_ack(32'h0);
    tick();
    imem_ack = 1'b0;
    tick(); tick();
    check_drained("rmd");
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_discard(1'b0);
    test_discard(1'b1);
    test_redirect_ack();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
